// File: rtl/if_id_pipe_reg_pkg.sv
// Shared pipeline-register definitions: occupancy encoding and default bubble payload,
// reused by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package if_id_pipe_reg_pkg;

    localparam int PIPE_DATA_W_DEFAULT = 64;
    localparam int PIPE_CNT_W_DEFAULT  = 16;

    localparam logic [PIPE_DATA_W_DEFAULT-1:0] PIPE_NOP_DEFAULT = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Handshake bundle between fetch, the IF/ID register and decode.
// slave = the pipeline register's view, master = the surrounding stages' view.
interface if_id_pipe_reg_if
    import if_id_pipe_reg_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DEFAULT,
    parameter int CNT_W  = PIPE_CNT_W_DEFAULT
);
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  bubble_cnt;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, bubble_cnt
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, bubble_cnt
    );
endinterface

// File: rtl/if_id_pipe_reg_skid_buf.sv
// Two-entry main+skid buffer with EMPTY/ONE/TWO occupancy; 1-cycle latency from empty.
// in_ready depends only on registered state, so a stall never reaches upstream combinationally.
module pipe_skid_buf
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                 DATA_W    = PIPE_DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0]  NOP_VALUE = DATA_W'(PIPE_NOP_DEFAULT)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clr_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
);

    occ_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              accept, pop;

    assign in_ready_o  = (state_q != OCC_TWO);
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign out_data_o  = out_valid_o ? main_q : NOP_VALUE;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clr_i) begin
            state_d = OCC_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_ONE;
                        main_d  = in_data_i;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        state_d = OCC_TWO;
                        skid_d  = in_data_i;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Older entry leaves from main; the skid entry moves up behind it.
                    if (pop) begin
                        state_d = OCC_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= OCC_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: skid-buffered, 1-cycle latency, in_ready never depends on out_ready.
// Flush drops held and incoming entries; bubble_cnt counts saturating decode-starved cycles.
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(PIPE_NOP_DEFAULT),
    parameter int                CNT_W     = PIPE_CNT_W_DEFAULT
) (
    input  logic             CLOCK,
    input  logic             RESET,
    if_id_pipe_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              buf_in_valid;
    logic              in_rdy;
    logic              out_vld;
    logic [DATA_W-1:0] out_dat;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    // A redirect kills the fetch arriving in the same cycle as well as everything held.
    assign buf_in_valid = bus.in_valid & ~bus.flush;

    pipe_skid_buf #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .clr_i       (bus.flush),
        .in_valid_i  (buf_in_valid),
        .in_data_i   (bus.in_data),
        .in_ready_o  (in_rdy),
        .out_valid_o (out_vld),
        .out_data_o  (out_dat),
        .out_ready_i (bus.out_ready)
    );

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = out_vld;
    assign bus.out_data   = out_dat;
    assign bus.bubble_cnt = bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bus.out_ready && !out_vld && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: table of per-cycle vectors plus saturation and reset sequences.
module tb_if_id_pipe_reg;

    localparam int          DW  = 64;
    localparam int          CW  = 4;
    localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

    logic CLOCK = 1'b0;
    logic RESET;

    if_id_pipe_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    if_id_pipe_reg #(
        .DATA_W    (DW),
        .NOP_VALUE (NOP),
        .CNT_W     (CW)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] id;
        logic        ordy;
        logic        e_ov;
        logic [63:0] e_od;
        logic        e_ir;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are changed at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] id, input logic ordy);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        //            fl    iv    data    ordy  ov    od      ir    cnt
        vecs[0]  = '{1'b0, 1'b1, 64'h04, 1'b0, 1'b1, 64'h04, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 64'h08, 1'b1, 1'b1, 64'h08, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 64'h0C, 1'b1, 1'b1, 64'h0C, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 64'h11, 1'b0, 1'b1, 64'h11, 1'b1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 64'h22, 1'b0, 1'b1, 64'h11, 1'b0, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 64'h99, 1'b0, 1'b1, 64'h11, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b1, 64'h22, 1'b1, 4'd0};
        vecs[8]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd0};
        vecs[9]  = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd1};
        vecs[10] = '{1'b0, 1'b1, 64'h55, 1'b0, 1'b1, 64'h55, 1'b1, 4'd1};
        vecs[11] = '{1'b0, 1'b1, 64'h66, 1'b0, 1'b1, 64'h55, 1'b0, 4'd1};
        vecs[12] = '{1'b1, 1'b1, 64'h33, 1'b0, 1'b0, NOP,    1'b1, 4'd1};
        vecs[13] = '{1'b0, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd2};
        vecs[14] = '{1'b0, 1'b1, 64'h77, 1'b0, 1'b1, 64'h77, 1'b1, 4'd2};
        vecs[15] = '{1'b1, 1'b1, 64'h88, 1'b1, 1'b0, NOP,    1'b1, 4'd2};
        vecs[16] = '{1'b0, 1'b1, 64'hAA, 1'b1, 1'b1, 64'hAA, 1'b1, 4'd3};
        vecs[17] = '{1'b1, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd3};
        vecs[18] = '{1'b1, 1'b0, 64'h00, 1'b1, 1'b0, NOP,    1'b1, 4'd4};

        RESET = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        @(negedge CLOCK);

        do_reset();
        chk("reset out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("reset out_data", bus.out_data, NOP);
        chk("reset in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("reset bubble_cnt", {60'h0, bus.bubble_cnt}, 64'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            tick();
            chk($sformatf("vec%0d out_valid", i), {63'h0, bus.out_valid}, {63'h0, vecs[i].e_ov});
            chk($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].e_od);
            chk($sformatf("vec%0d in_ready", i), {63'h0, bus.in_ready}, {63'h0, vecs[i].e_ir});
            chk($sformatf("vec%0d bubble_cnt", i), {60'h0, bus.bubble_cnt}, {60'h0, vecs[i].e_cnt});
        end

        // Starved decode for 20 cycles: counter climbs to 15 and sticks.
        do_reset();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("sat cycle%0d", i), {60'h0, bus.bubble_cnt},
                (i + 1 >= 15) ? 64'd15 : 64'(i + 1));
        end

        // Reset while stalled full with a non-zero bubble count.
        do_reset();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        repeat (5) tick();
        drive(1'b0, 1'b1, 64'hA1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 64'hB2, 1'b0);
        tick();
        chk("pre-reset in_ready", {63'h0, bus.in_ready}, 64'h0);
        chk("pre-reset bubble_cnt", {60'h0, bus.bubble_cnt}, 64'd5);
        chk("pre-reset out_data", bus.out_data, 64'hA1);
        RESET = 1'b1;
        drive(1'b1, 1'b1, 64'hBB, 1'b1);
        tick();
        RESET = 1'b0;
        chk("midreset out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("midreset out_data", bus.out_data, NOP);
        chk("midreset in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("midreset bubble_cnt", {60'h0, bus.bubble_cnt}, 64'h0);
        drive(1'b0, 1'b1, 64'h44, 1'b0);
        tick();
        chk("post-reset out_valid", {63'h0, bus.out_valid}, 64'h1);
        chk("post-reset out_data", bus.out_data, 64'h44);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        chk("post-reset drain", {63'h0, bus.out_valid}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 SHALL take parameter DATA_W, default 64, meaning payload width ({instruction, PC+4} in the IF/ID use).
REQ-002 SHALL take parameter NOP_VALUE, default all-zero, meaning the payload presented while the stage holds a bubble.
REQ-003 SHALL take parameter CNT_W, default 16, meaning the bubble counter width.
REQ-004 SHALL have port CLOCK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  kill all held entries (branch/jump redirect).
REQ-007 SHALL have port in_valid  input  1  upstream (fetch) payload valid.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-010 SHALL have port out_valid  output  1  downstream (decode) payload valid.
REQ-011 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-012 SHALL have port out_ready  input  1  downstream consumes this cycle; low = stall.
REQ-013 SHALL have port bubble_cnt  output  CNT_W  count of decode-starved cycles.

Function
REQ-014 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-015 SHALL hold a main register and one skid register, with occupancy FSM states EMPTY, ONE and TWO.
REQ-016 SHALL drive in_ready = (state != TWO), decoded only from registered state, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (state != EMPTY), and out_data = main when valid, else NOP_VALUE.
REQ-018 SHALL transition EMPTY: accept -> ONE with main <= in_data; otherwise stay EMPTY.
REQ-019 SHALL transition ONE:
- accept & pop -> ONE, main <= in_data.
- accept & !pop -> TWO, skid <= in_data.
- pop & !accept -> EMPTY.
- neither -> hold.
REQ-020 SHALL transition TWO: pop -> ONE with main <= skid; otherwise hold, with no accept possible.
REQ-021 SHALL give a latency of exactly 1 cycle from accept into EMPTY to out_valid=1 with that payload.
REQ-022 SHALL deliver payloads in acceptance order, never duplicated, never dropped except by flush or RESET.
REQ-023 SHALL, on flush=1, go to EMPTY next cycle and set main and skid to NOP_VALUE; flush has priority over a simultaneous accept (input dropped) and a simultaneous pop (the pop completes downstream, but the state still clears).
REQ-024 SHALL NOT let flush modify bubble_cnt.
REQ-025 SHALL increment bubble_cnt in each cycle with out_ready=1 and out_valid=0, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-027 SHALL, on RESET=1 at a rising edge, set state=EMPTY, main=skid=NOP_VALUE and bubble_cnt=0; the resulting outputs are out_valid=0, out_data=NOP_VALUE and in_ready=1.
REQ-028 SHALL give RESET priority over flush, accept and pop.
REQ-029 SHALL, on RESET asserted mid-stall in TWO, discard both entries, and the first post-reset accept SHALL behave as from EMPTY.

Structure
REQ-030 SHALL place the occupancy state encoding (EMPTY/ONE/TWO) and the default NOP_VALUE constant in the shared pipeline package, reused by the ID/EX, EX/MEM and MEM/WB stages.
REQ-031 SHALL use one sub-module, pipe_skid_buf (main+skid storage and FSM), while the bubble counter and flush logic stay in the top.

Verification
REQ-032 SHALL verify streaming: in_valid=1, out_ready=1, in_data=0x...0004, 0x...0008, 0x...000C on consecutive cycles -> same three values on out_data one cycle later, in_ready stays 1, bubble_cnt=0.
REQ-033 SHALL verify stall fill: in ONE holding A=0x11, out_ready=0, accept B=0x22 -> state TWO, in_ready=0, out_data=0x11; then out_ready=1 -> 0x11, then 0x22, each in its own cycle.
REQ-034 SHALL verify flush: state TWO, flush=1 with in_valid=1 and in_data=0x33 -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, and 0x33 never appears.
REQ-035 SHALL verify saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and stays 15.
REQ-036 SHALL verify reset mid-operation: state TWO with bubble_cnt=5, RESET=1 for one cycle -> out_valid=0, in_ready=1, bubble_cnt=0; the next accept of 0x44 appears 1 cycle later.
